// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Pipeline sequencing controller for the two-slot (ALU + MEM) VLIW core.
//   - Detects load-use hazards that forwarding cannot cover and inserts
//     LOAD_BUBBLES bubbles into p2. It does this by holding PC/p1 and
//     loading NOP into p2.
//   - Freezes the whole pipeline while a p3 memory access waits on
//     mem_ready. A watchdog releases the freeze after MEM_TIMEOUT cycles
//     and raises a sticky mem_err.
//   - Keeps a saturating count of stalled/frozen cycles.
//
// Ports
//   clk, rst                   : clock (rising edge), synchronous active-high reset
//   p1_aluOpcode/p1_memOpcode  : decode-stage opcodes of the ALU and MEM slots
//   p1_opcodeA_rm/_rn          : decode-stage ALU source registers
//   p1_opcodeM_rn/_rd          : decode-stage MEM address / store-data registers
//   p2_memOpcode, p2_mem_regWrite, p2_opcodeM_rd : execute-stage MEM slot
//   p3_memOpcode, mem_ready    : memory-stage opcode and completion strobe
//   stall_front                : hold PC and p1
//   bubble_p2                  : load NOP into both p2 slots
//   freeze                     : hold p1..p4 and PC, suppress RF writes
//   mem_req                    : p3 holds a memory access
//   mem_err                    : sticky watchdog-timeout flag
//   state                      : 0 RUN, 1 LU_STALL, 2 MEM_WAIT
//   stall_cycles               : saturating count of stall_front|freeze cycles
module hazard_stall_ctrl #(
  parameter logic [4:0]  NOP_OPCODE   = 5'd0,
  parameter logic [4:0]  LOAD_OPCODE  = 5'd8,
  parameter logic [4:0]  STORE_OPCODE = 5'd9,
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  p1_aluOpcode,
  input  logic [4:0]  p1_memOpcode,
  input  logic [2:0]  p1_opcodeA_rm,
  input  logic [2:0]  p1_opcodeA_rn,
  input  logic [2:0]  p1_opcodeM_rn,
  input  logic [2:0]  p1_opcodeM_rd,
  input  logic [4:0]  p2_memOpcode,
  input  logic        p2_mem_regWrite,
  input  logic [2:0]  p2_opcodeM_rd,
  input  logic [4:0]  p3_memOpcode,
  input  logic        mem_ready,
  output logic        stall_front,
  output logic        bubble_p2,
  output logic        freeze,
  output logic        mem_req,
  output logic        mem_err,
  output logic [1:0]  state,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // Bubbles still owed after the one issued in the hazard cycle itself.
  localparam logic [1:0] LU_RELOAD  = 2'(LOAD_BUBBLES - 1);
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

  function automatic logic [15:0] satInc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      curState, nxtState;
  logic [1:0]  luCnt, nxtLu;
  logic [7:0]  waitCnt, nxtWait;
  logic        memErr, setErr;
  logic [15:0] stallCnt;

  logic aluActive, memActive, isStore, hazardLu;
  logic memReq, memBusy;
  logic stallFront, freezeInt;
  logic evalRun, evalLu, busyEff;

  // Decode-stage source matching against the loaded register (r0 included).
  assign aluActive = (p1_aluOpcode != NOP_OPCODE);
  assign memActive = (p1_memOpcode != NOP_OPCODE);
  assign isStore   = (p1_memOpcode == STORE_OPCODE);

  assign hazardLu = (p2_memOpcode == LOAD_OPCODE) && p2_mem_regWrite &&
                    ((aluActive && ((p1_opcodeA_rm == p2_opcodeM_rd) ||
                                    (p1_opcodeA_rn == p2_opcodeM_rd))) ||
                     (memActive && (p1_opcodeM_rn == p2_opcodeM_rd)) ||
                     (isStore   && (p1_opcodeM_rd == p2_opcodeM_rd)));

  assign memReq  = (p3_memOpcode != NOP_OPCODE);
  assign memBusy = memReq && !mem_ready;

  always_comb begin
    stallFront = 1'b0;
    freezeInt  = 1'b0;
    nxtState   = curState;
    nxtLu      = luCnt;
    nxtWait    = waitCnt;
    setErr     = 1'b0;
    evalRun    = 1'b0;
    evalLu     = 1'b0;
    busyEff    = memBusy;

    case (curState)
      RUN:      evalRun = 1'b1;
      LU_STALL: evalLu  = 1'b1;
      MEM_WAIT: begin
        if (!mem_ready && (waitCnt < WAIT_LIMIT)) begin
          freezeInt = 1'b1;
          nxtWait   = waitCnt + 8'd1;
        end else begin
          // Exit cycle: p3 is released (ready or watchdog), so the cycle is
          // handled like the bubble/run logic with no memory stall pending.
          setErr  = !mem_ready;
          busyEff = 1'b0;
          evalLu  = (luCnt != 2'd0);
          evalRun = (luCnt == 2'd0);
        end
      end
      default:  nxtState = RUN;
    endcase

    if (evalRun || evalLu) begin
      if (busyEff) begin
        // Freeze wins; any owed bubbles stay in luCnt until the wait ends.
        freezeInt = 1'b1;
        nxtWait   = 8'd1;
        nxtState  = MEM_WAIT;
      end else if (evalLu) begin
        stallFront = 1'b1;
        nxtLu      = luCnt - 2'd1;
        nxtState   = (luCnt == 2'd1) ? RUN : LU_STALL;
      end else if (hazardLu) begin
        stallFront = 1'b1;
        if (LOAD_BUBBLES > 1) begin
          nxtLu    = LU_RELOAD;
          nxtState = LU_STALL;
        end else begin
          nxtState = RUN;
        end
      end else begin
        nxtState = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      curState <= RUN;
      luCnt    <= 2'd0;
      waitCnt  <= 8'd0;
      memErr   <= 1'b0;
      stallCnt <= 16'd0;
    end else begin
      curState <= nxtState;
      luCnt    <= nxtLu;
      waitCnt  <= nxtWait;
      if (setErr) memErr <= 1'b1;
      if (stallFront || freezeInt) stallCnt <= satInc16(stallCnt);
    end
  end

  // Everything reads as zero while reset is held, including the registered
  // outputs during the reset cycle itself.
  assign stall_front  = !rst && stallFront;
  assign bubble_p2    = !rst && stallFront;
  assign freeze       = !rst && freezeInt;
  assign mem_req      = !rst && memReq;
  assign mem_err      = !rst && memErr;
  assign state        = rst ? 2'd0 : curState;
  assign stall_cycles = rst ? 16'd0 : stallCnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

  localparam int TIMEOUT = 8;

  logic       clk;
  logic       rst;
  logic [4:0] aluOp, memOp, p2Op, p3Op;
  logic [2:0] rm, rn, mrn, mrd, p2Rd;
  logic       p2Rw, ready;

  logic [1:0]  sfV, bbV, frV, mrV, meV;
  logic [1:0]  stV [2];
  logic [15:0] scV [2];

  int passCnt  = 0;
  int totalCnt = 0;
  int failCnt  = 0;

  typedef struct {
    int bubblesLeft;
    bit waiting;
    int waited;
    bit err;
    int stalls;
  } mdl_t;

  mdl_t mdl [2];
  int   lbOf [2] = '{1, 3};

  hazard_stall_ctrl #(.LOAD_BUBBLES(1), .MEM_TIMEOUT(TIMEOUT)) dut1 (
    .clk(clk), .rst(rst),
    .p1_aluOpcode(aluOp), .p1_memOpcode(memOp),
    .p1_opcodeA_rm(rm), .p1_opcodeA_rn(rn),
    .p1_opcodeM_rn(mrn), .p1_opcodeM_rd(mrd),
    .p2_memOpcode(p2Op), .p2_mem_regWrite(p2Rw), .p2_opcodeM_rd(p2Rd),
    .p3_memOpcode(p3Op), .mem_ready(ready),
    .stall_front(sfV[0]), .bubble_p2(bbV[0]), .freeze(frV[0]),
    .mem_req(mrV[0]), .mem_err(meV[0]), .state(stV[0]), .stall_cycles(scV[0])
  );

  hazard_stall_ctrl #(.LOAD_BUBBLES(3), .MEM_TIMEOUT(TIMEOUT)) dut3 (
    .clk(clk), .rst(rst),
    .p1_aluOpcode(aluOp), .p1_memOpcode(memOp),
    .p1_opcodeA_rm(rm), .p1_opcodeA_rn(rn),
    .p1_opcodeM_rn(mrn), .p1_opcodeM_rd(mrd),
    .p2_memOpcode(p2Op), .p2_mem_regWrite(p2Rw), .p2_opcodeM_rd(p2Rd),
    .p3_memOpcode(p3Op), .mem_ready(ready),
    .stall_front(sfV[1]), .bubble_p2(bbV[1]), .freeze(frV[1]),
    .mem_req(mrV[1]), .mem_err(meV[1]), .state(stV[1]), .stall_cycles(scV[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: bubbles owed, whether a memory wait is in progress and how
  // long it has lasted, error flag and stall total.
  task automatic modelCheck(input int i);
    mdl_t        m;
    logic [7:0]  reads;
    logic        hz, busy, eSf, eFr, eMr, eMe;
    logic [1:0]  eSt;
    logic [15:0] eSc;
    m = mdl[i];
    reads = 8'h00;
    if (aluOp != 5'd0) begin reads[rm] = 1'b1; reads[rn] = 1'b1; end
    if (memOp != 5'd0) reads[mrn] = 1'b1;
    if (memOp == 5'd9) reads[mrd] = 1'b1;
    hz = (p2Op == 5'd8) && p2Rw && reads[p2Rd];
    eSf = 1'b0; eFr = 1'b0; eMr = 1'b0; eMe = 1'b0; eSt = 2'd0; eSc = 16'd0;
    if (rst) begin
      m = '{default: 0};
    end else begin
      eMr  = (p3Op != 5'd0);
      eMe  = m.err;
      eSc  = 16'(m.stalls);
      eSt  = m.waiting ? 2'd2 : ((m.bubblesLeft > 0) ? 2'd1 : 2'd0);
      busy = eMr && !ready;
      if (m.waiting) begin
        if (!ready && m.waited < TIMEOUT) begin
          eFr = 1'b1;
          m.waited++;
        end else begin
          if (!ready) m.err = 1'b1;
          m.waiting = 1'b0;
          busy = 1'b0;
        end
      end
      if (!m.waiting) begin
        if (busy) begin
          eFr = 1'b1; m.waiting = 1'b1; m.waited = 1;
        end else if (m.bubblesLeft > 0) begin
          eSf = 1'b1; m.bubblesLeft--;
        end else if (hz) begin
          eSf = 1'b1; m.bubblesLeft = lbOf[i] - 1;
        end
      end
      if ((eSf || eFr) && m.stalls < 65535) m.stalls++;
    end
    check($sformatf("lb%0d.stall_front", lbOf[i]), sfV[i], eSf);
    check($sformatf("lb%0d.bubble_p2", lbOf[i]), bbV[i], eSf);
    check($sformatf("lb%0d.freeze", lbOf[i]), frV[i], eFr);
    check($sformatf("lb%0d.mem_req", lbOf[i]), mrV[i], eMr);
    check($sformatf("lb%0d.mem_err", lbOf[i]), meV[i], eMe);
    check($sformatf("lb%0d.state", lbOf[i]), stV[i], eSt);
    check($sformatf("lb%0d.stall_cycles", lbOf[i]), scV[i], eSc);
    mdl[i] = m;
  endtask

  task automatic settle();
    @(negedge clk);
    modelCheck(0);
    modelCheck(1);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; aluOp = 5'd0; memOp = 5'd0; rm = 3'd0; rn = 3'd0;
    mrn = 3'd0; mrd = 3'd0; p2Op = 5'd0; p2Rw = 1'b0; p2Rd = 3'd0;
    p3Op = 5'd0; ready = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    idle();
    for (int k = 0; k < n; k++) begin settle(); advance(); end
  endtask

  task automatic setLoadUse();
    idle();
    p2Op = 5'd8; p2Rd = 3'd3; p2Rw = 1'b1; aluOp = 5'd1; rm = 3'd3;
  endtask

  initial begin
    logic [1:0]  expSt [4];
    logic [4:0]  memChoices [4];
    int          bubbles, freezes;
    mdl[0] = '{default: 0};
    mdl[1] = '{default: 0};
    memChoices = '{5'd0, 5'd8, 5'd9, 5'd3};

    // Reset
    idle(); rst = 1'b1;
    settle();
    check("reset.outs", {sfV, bbV, frV, mrV, meV}, 0);
    check("reset.state", stV[0], 0);
    check("reset.count", scV[0], 0);
    advance(); settle(); advance();
    idleCycles(2);

    // Basic load-use
    setLoadUse();
    settle();
    check("lu.stall", sfV[0], 1);
    check("lu.bubble", bbV[0], 1);
    check("lu.state", stV[0], 0);
    advance();
    idle();
    settle();
    check("lu.release", sfV[0], 0);
    check("lu.count", scV[0], 1);
    check("lu.state_after", stV[0], 0);
    advance();
    idleCycles(3);

    // No hazard: regWrite low, then ALU NOP
    setLoadUse(); p2Rw = 1'b0;
    settle(); check("nohz.regwrite", sfV, 0); advance();
    setLoadUse(); aluOp = 5'd0;
    settle(); check("nohz.alunop", sfV, 0); advance();
    idleCycles(1);

    // Store-data source, three bubbles on the LOAD_BUBBLES=3 instance
    expSt = '{2'd0, 2'd1, 2'd1, 2'd0};
    idle(); memOp = 5'd9; mrd = 3'd5; p2Op = 5'd8; p2Rd = 3'd5; p2Rw = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      check($sformatf("store.stall%0d", k), sfV[1], (k < 3) ? 1 : 0);
      check($sformatf("store.state%0d", k), stV[1], expSt[k]);
      advance();
      idle();
    end
    idleCycles(1);

    // Memory wait: ready after 4 frozen cycles
    idle(); p3Op = 5'd8;
    for (int k = 0; k < 5; k++) begin
      ready = (k == 4);
      settle();
      check($sformatf("mw.freeze%0d", k), frV[0], (k < 4) ? 1 : 0);
      check($sformatf("mw.state%0d", k), stV[0], (k == 0) ? 0 : 2);
      check($sformatf("mw.err%0d", k), meV[0], 0);
      advance();
    end
    idleCycles(1);
    check("mw.back_run", stV[0], 0);

    // Timeout: mem_ready never arrives
    idle(); p3Op = 5'd8;
    for (int k = 0; k < 9; k++) begin
      settle();
      check($sformatf("to.freeze%0d", k), frV, (k < 8) ? 2'b11 : 2'b00);
      advance();
    end
    idleCycles(1);
    check("to.err", meV, 2'b11);
    idleCycles(3);
    check("to.err_sticky", meV, 2'b11);
    idle(); rst = 1'b1;
    settle(); check("to.err_rst", meV, 0); advance();
    idleCycles(1);
    check("to.err_cleared", meV, 0);

    // Overlap: memory stall begins in the 2nd bubble of a 3-bubble stall
    bubbles = 0; freezes = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 1) setLoadUse();
      else begin
        idle();
        if (k >= 2 && k <= 5) begin p3Op = 5'd8; ready = (k == 5); end
      end
      settle();
      bubbles += int'(bbV[1]);
      freezes += int'(frV[1]);
      advance();
    end
    check("ovl.bubbles", bubbles, 3);
    check("ovl.freezes", freezes, 3);
    idleCycles(2);

    // Reset during MEM_WAIT
    idle(); p3Op = 5'd8;
    for (int k = 0; k < 3; k++) begin settle(); advance(); end
    check("rstw.in_wait", stV[0], 2);
    idle(); rst = 1'b1;
    settle();
    check("rstw.outs", {sfV, bbV, frV, mrV, meV}, 0);
    check("rstw.state", {stV[0], stV[1]}, 0);
    check("rstw.count", {scV[0], scV[1]}, 0);
    advance();
    idle();
    settle();
    check("rstw.freeze_after", frV, 0);
    check("rstw.state_after", {stV[0], stV[1]}, 0);
    advance();

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      rst   = ($urandom_range(0, 99) == 0);
      aluOp = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      memOp = memChoices[$urandom_range(0, 3)];
      rm    = 3'($urandom_range(0, 7));
      rn    = 3'($urandom_range(0, 7));
      mrn   = 3'($urandom_range(0, 7));
      mrd   = 3'($urandom_range(0, 7));
      p2Op  = memChoices[$urandom_range(0, 3)];
      p2Rw  = 1'($urandom_range(0, 1));
      p2Rd  = 3'($urandom_range(0, 7));
      p3Op  = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd8;
      ready = ($urandom_range(0, 9) < 3);
      settle();
      advance();
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
